// File: rtl/result_argmax.sv
// Argmax over the ten MLP class scores. The block waits a settle time after start, takes a
// snapshot of the scores, then scans them with one compare per cycle.
module result_argmax #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          SIGNED_SCORES = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [0:DATA_W-1] scores [9:0],
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [3:0]        digit,
    output logic [0:DATA_W-1] max_score
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("result_argmax: SETTLE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StSettle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [0:DATA_W-1] snap_q [9:0];
    logic [0:DATA_W-1] snap_d [9:0];
    logic [0:DATA_W-1] best_val_q, best_val_d;
    logic [3:0]        best_idx_q, best_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        digit_q, digit_d;
    logic [0:DATA_W-1] max_q, max_d;
    logic              cand_gt;

    function automatic logic score_gt(input logic [0:DATA_W-1] a, input logic [0:DATA_W-1] b);
        if (SIGNED_SCORES) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        out_valid_d = out_valid_q;
        digit_d     = digit_q;
        max_d       = max_q;
        cand_gt     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StSettle;
                    cnt_d       = 8'(SETTLE_CYCLES - 1);
                    out_valid_d = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    snap_d     = scores;
                    best_val_d = scores[0];
                    best_idx_d = 4'd0;
                    idx_d      = 4'd1;
                    state_d    = StScan;
                end
            end
            StScan: begin
                // Strict compare keeps the lowest index on ties.
                cand_gt = score_gt(snap_q[idx_q], best_val_q);
                if (cand_gt) begin
                    best_val_d = snap_q[idx_q];
                    best_idx_d = idx_q;
                end
                if (idx_q == 4'd9) begin
                    digit_d     = cand_gt ? idx_q : best_idx_q;
                    max_d       = cand_gt ? snap_q[idx_q] : best_val_q;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            idx_q       <= 4'd0;
            snap_q      <= '{default: '0};
            best_val_q  <= '0;
            best_idx_q  <= 4'd0;
            out_valid_q <= 1'b0;
            digit_q     <= 4'd0;
            max_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            out_valid_q <= out_valid_d;
            digit_q     <= digit_d;
            max_q       <= max_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign out_valid = out_valid_q;
    assign digit     = digit_q;
    assign max_score = max_q;

endmodule
